// File: rtl/cdot_operand_packer.sv
// cdot_operand_packer: buffers SIZE element beats, issues them to the complex dot-product engine, returns its result downstream.
module cdot_operand_packer #(
  parameter int SIZE         = 16,
  parameter int WIDTH        = 64,
  parameter int NUM_OPERANDS = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic                               s_valid_i,
  output logic                               s_ready_o,
  input  logic [NUM_OPERANDS*WIDTH-1:0]      s_data_i,
  output logic                               mul_valid_o,
  input  logic                               mul_ready_i,
  output logic [SIZE*NUM_OPERANDS*WIDTH-1:0] mul_operands_o,
  input  logic                               mul_result_valid_i,
  output logic                               mul_result_ready_o,
  input  logic [2*WIDTH-1:0]                 mul_result_i,
  output logic                               r_valid_o,
  input  logic                               r_ready_i,
  output logic [WIDTH-1:0]                   r_real_o,
  output logic [WIDTH-1:0]                   r_imag_o,
  output logic                               busy_o
);
  localparam int BW = NUM_OPERANDS * WIDTH;
  localparam int CW = $clog2(SIZE);
  typedef enum logic [1:0] {FILL, ISSUE, WAIT, RESULT} state_t;
  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [SIZE*BW-1:0] r_buf;
  logic [WIDTH-1:0]   r_re, r_im;
  logic               w_acc, w_last, w_cap;
  assign w_acc  = (r_state == FILL) && s_valid_i;
  assign w_last = r_cnt == CW'(SIZE - 1);
  assign w_cap  = (r_state == WAIT) && mul_result_valid_i;
  // flush outranks every other transition
  always_comb begin
    w_next = flush_i                              ? FILL   :
             (w_acc && w_last)                    ? ISSUE  :
             (r_state == ISSUE && mul_ready_i)    ? WAIT   :
             w_cap                                ? RESULT :
             (r_state == RESULT && r_ready_i)     ? FILL   : r_state;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= FILL;
    else       r_state <= w_next;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_buf <= '0;
      r_re  <= '0;
      r_im  <= '0;
    end else begin
      if (flush_i) r_cnt <= '0;
      else if (w_acc) begin
        r_buf[int'(r_cnt)*BW +: BW] <= s_data_i;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
      if (w_cap && !flush_i) {r_im, r_re} <= mul_result_i;
    end
  end
  assign s_ready_o          = r_state == FILL;
  assign mul_valid_o        = r_state == ISSUE;
  assign mul_result_ready_o = r_state == WAIT;
  assign r_valid_o          = r_state == RESULT;
  assign mul_operands_o     = r_buf;
  assign r_real_o           = r_re;
  assign r_imag_o           = r_im;
  assign busy_o             = !(r_state == FILL && r_cnt == '0);
endmodule

// File: tb/tb_cdot_operand_packer.sv
// tb_cdot_operand_packer: scoreboard bench; stimulus queues expected issues/results, a negedge monitor checks them.
module tb_cdot_operand_packer;
  localparam int S = 16, W = 64, N = 4, BW = N * W, VW = S * BW;
  typedef logic [VW-1:0] vec_t;
  logic clk = 0, rst_i = 1, flush_i = 0, s_valid_i = 0, mul_ready_i = 0;
  logic mul_result_valid_i = 0, r_ready_i = 0;
  logic [BW-1:0] s_data_i = '0;
  logic [2*W-1:0] mul_result_i = '0;
  logic s_ready_o, mul_valid_o, mul_result_ready_o, r_valid_o, busy_o;
  logic [VW-1:0] mul_operands_o;
  logic [W-1:0] r_real_o, r_imag_o;
  vec_t q_ops[$];
  logic [2*W-1:0] q_res[$];
  vec_t cur_ops;
  int n_cmp = 0, n_err = 0;

  cdot_operand_packer #(.SIZE(S), .WIDTH(W), .NUM_OPERANDS(N)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .mul_valid_o(mul_valid_o), .mul_ready_i(mul_ready_i), .mul_operands_o(mul_operands_o),
    .mul_result_valid_i(mul_result_valid_i), .mul_result_ready_o(mul_result_ready_o),
    .mul_result_i(mul_result_i), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
    .r_real_o(r_real_o), .r_imag_o(r_imag_o), .busy_o(busy_o));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input vec_t act, input vec_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      for (int j = 0; j < S * N; j++)
        if (act[j*W +: W] !== exp[j*W +: W]) begin
          $display("FAIL %s word %0d: got %h expected %h", name, j, act[j*W +: W], exp[j*W +: W]);
          break;
        end
    end
  endtask

  function automatic logic [BW-1:0] beat(input int v, input int i);
    logic [BW-1:0] b;
    if (v == 0) b = {64'h4000000000000000, 64'h401C000000000000, 64'h4000000000000000, 64'h3FF0000000000000};
    else for (int k = 0; k < N; k++) b[k*W +: W] = {16'h4010, 8'(v), 8'(i), 16'h0, 16'(k)};
    return b;
  endfunction

  // Lane k of beat i must land at operand word i*N+k, i.e. beat i occupies bits [i*BW +: BW].
  task automatic send(input int v, input int n, input bit gaps, input bit push);
    vec_t e = '0;
    int i = 0, guard = 0;
    bit acc;
    while (i < n && guard < 400) begin
      s_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data_i  = beat(v, i);
      chk("fill_s_ready", s_ready_o, 1);
      acc = s_valid_i && s_ready_o;
      if (acc) e[i*BW +: BW] = beat(v, i);
      tick();
      if (acc) i++;
      guard++;
      if (i < n && i > 0 && acc) chk("early_issue", mul_valid_o, 0);
    end
    s_valid_i = 0;
    if (guard >= 400) chk("send_timeout", 0, 1);
    if (n == S) begin
      chk("issue_valid", mul_valid_o, 1);
      chk("issue_s_ready", s_ready_o, 0);
      chk("issue_busy", busy_o, 1);
      cur_ops = e;
      if (push) q_ops.push_back(e);
    end
  endtask

  task automatic engine(input int stall, input int lat, input logic [W-1:0] re, input logic [W-1:0] im,
                        input bit push_res, input bit give);
    repeat (stall) begin
      tick();
      chk("stall_valid", mul_valid_o, 1);
      chkv("stall_ops", mul_operands_o, cur_ops);
    end
    mul_ready_i = 1;
    tick();
    mul_ready_i = 0;
    chk("wait_res_ready", mul_result_ready_o, 1);
    chk("wait_s_ready", s_ready_o, 0);
    if (give) begin
      repeat (lat) tick();
      if (push_res) q_res.push_back({im, re});
      mul_result_valid_i = 1;
      mul_result_i = {im, re};
      tick();
      mul_result_valid_i = 0;
      chk("result_valid", r_valid_o, 1);
      chk("result_real", r_real_o, re);
      chk("result_imag", r_imag_o, im);
      chk("result_res_ready", mul_result_ready_o, 0);
    end
  endtask

  task automatic drain(input int hold, input logic [W-1:0] re, input logic [W-1:0] im);
    repeat (hold) begin
      tick();
      chk("hold_valid", r_valid_o, 1);
      chk("hold_data", {r_imag_o, r_real_o}, {im, re});
    end
    r_ready_i = 1;
    tick();
    r_ready_i = 0;
    chk("back_s_ready", s_ready_o, 1);
    chk("back_r_valid", r_valid_o, 0);
    chk("back_busy", busy_o, 0);
  endtask

  task automatic flush_chk(input string name);
    flush_i = 1;
    tick();
    flush_i = 0;
    chk({name, "_s_ready"}, s_ready_o, 1);
    chk({name, "_mul_valid"}, mul_valid_o, 0);
    chk({name, "_res_ready"}, mul_result_ready_o, 0);
    chk({name, "_r_valid"}, r_valid_o, 0);
    chk({name, "_busy"}, busy_o, 0);
  endtask

  task automatic late_result();
    mul_result_valid_i = 1;
    mul_result_i = {64'hDEAD, 64'hBEEF};
    tick();
    mul_result_valid_i = 0;
    chk("late_r_valid", r_valid_o, 0);
    chk("late_busy", busy_o, 0);
  endtask

  task automatic reset_chk(input string name);
    chk({name, "_s_ready"}, s_ready_o, 1);
    chk({name, "_mul_valid"}, mul_valid_o, 0);
    chk({name, "_res_ready"}, mul_result_ready_o, 0);
    chk({name, "_r_valid"}, r_valid_o, 0);
    chk({name, "_busy"}, busy_o, 0);
    chk({name, "_result"}, {r_imag_o, r_real_o}, 0);
    chkv({name, "_ops"}, mul_operands_o, '0);
  endtask

  always @(negedge clk) begin
    if (!rst_i) begin
      if (mul_valid_o && mul_ready_i) begin
        if (q_ops.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_issue: got issue expected none");
        end else chkv("issue_ops", mul_operands_o, q_ops.pop_front());
      end
      if (r_valid_o && r_ready_i) begin
        if (q_res.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_result: got %h expected none", {r_imag_o, r_real_o});
        end else chk("result_out", {r_imag_o, r_real_o}, q_res.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    reset_chk("rst_hold");
    tick();
    rst_i = 0;
    tick();
    reset_chk("rst_rel");
    // basic fill + engine backpressure, 48+256j
    send(0, S, 0, 1);
    engine(5, 2, 64'h4048000000000000, 64'h4070000000000000, 1, 1);
    drain(3, 64'h4048000000000000, 64'h4070000000000000);
    // upstream gaps
    send(1, S, 1, 1);
    engine(0, 1, 64'h3FF8000000000000, 64'hC000000000000000, 1, 1);
    drain(0, 64'h3FF8000000000000, 64'hC000000000000000);
    // flush in FILL at cnt=7
    send(2, 7, 0, 0);
    chk("partial_busy", busy_o, 1);
    chk("partial_mul_valid", mul_valid_o, 0);
    flush_chk("flush_fill");
    // flush in ISSUE
    send(3, S, 0, 0);
    flush_chk("flush_issue");
    late_result();
    // flush in WAIT
    send(4, S, 0, 1);
    engine(0, 0, 64'h0, 64'h0, 0, 0);
    flush_chk("flush_wait");
    late_result();
    // flush in RESULT
    send(5, S, 0, 1);
    engine(1, 0, 64'h4014000000000000, 64'h4018000000000000, 0, 1);
    flush_chk("flush_result");
    // async reset mid-WAIT, applied between edges
    send(6, S, 0, 1);
    engine(0, 0, 64'h0, 64'h0, 0, 0);
    #3;
    rst_i = 1;
    #1;
    reset_chk("async_rst");
    @(negedge clk);
    rst_i = 0;
    tick();
    send(7, S, 1, 1);
    engine(2, 3, 64'h4022000000000000, 64'h4024000000000000, 1, 1);
    drain(1, 64'h4022000000000000, 64'h4024000000000000);
    // back-to-back transactions
    for (int v = 8; v <= 10; v++) begin
      send(v, S, 0, 1);
      engine(v % 3, v % 2, 64'h4000000000000000 + 64'(v), 64'hC000000000000000 + 64'(v), 1, 1);
      drain(v % 2, 64'h4000000000000000 + 64'(v), 64'hC000000000000000 + 64'(v));
    end
    tick();
    chk("ops_queue_empty", 32'(q_ops.size()), 0);
    chk("res_queue_empty", 32'(q_res.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cdot_operand_packer.md
# cdot_operand_packer

Initiator-side front end for the `complex_matrix_mul` complex dot-product engine. It collects one complex element pair per beat from an upstream stream until `SIZE` elements are buffered. It then presents the packed operand vector to the engine with a valid/ready handshake, captures the engine's two-word complex result, and hands that result downstream on a result stream. It sits between the operand DMA/stream fabric and the engine, replacing bench-driven static operands.

## Interface
- `SIZE`, 16, number of complex element pairs per dot product (≥2).
- `WIDTH`, 64, word width; IEEE-754 double bit patterns, passed through untouched.
- `NUM_OPERANDS`, 4, words per element beat: lane0 = V1 real, lane1 = V1 imag, lane2 = V2 real, lane3 = V2 imag.
- `clk_i` in 1 — single clock; all state on rising edge.
- `rst_i` in 1 — asynchronous, active-high reset.
- `flush_i` in 1 — synchronous abort; returns the block to idle fill.
- `s_valid_i` in 1 — upstream beat valid.
- `s_ready_o` out 1 — block can accept a beat.
- `s_data_i` in `NUM_OPERANDS*WIDTH` — one element beat; lane k = bits [k*WIDTH +: WIDTH].
- `mul_valid_o` out 1 — operand vector valid to the engine (engine `in_valid_i`).
- `mul_ready_i` in 1 — engine `in_ready_o`.
- `mul_operands_o` out `SIZE*NUM_OPERANDS*WIDTH` — packed operands; word i*NUM_OPERANDS+k = lane k of beat i.
- `mul_result_valid_i` in 1 — engine `out_valid_o`.
- `mul_result_ready_o` out 1 — engine `out_ready_i`.
- `mul_result_i` in `2*WIDTH` — engine result; word0 real, word1 imag.
- `r_valid_o` out 1 — captured result valid downstream.
- `r_ready_i` in 1 — downstream accepts result.
- `r_real_o`, `r_imag_o` out `WIDTH` each — captured result words.
- `busy_o` out 1 — high in any state except FILL with count 0.

## Operation
- State machine: FILL → ISSUE → WAIT → RESULT → FILL.
- FILL: `s_ready_o`=1. Each `s_valid_i & s_ready_o` writes `s_data_i` into slot `cnt` and increments `cnt`. Acceptance with `cnt==SIZE-1` → ISSUE, `cnt`←0.
- ISSUE: `s_ready_o`=0, `mul_valid_o`=1, `mul_operands_o` stable. On `mul_ready_i` → WAIT. `mul_valid_o` never drops before handshake.
- WAIT: `mul_result_ready_o`=1. On `mul_result_valid_i`, capture `mul_result_i` into `r_real_o`/`r_imag_o` → RESULT.
- RESULT: `r_valid_o`=1, result stable. On `r_ready_i` → FILL.
- A result that arrives outside WAIT is ignored: `mul_result_ready_o`=0 everywhere else.
- No arithmetic on data. `cnt` is $clog2(SIZE) bits and does not wrap except via the SIZE-1 transition.
- `flush_i` has priority over every transition. Next state is FILL with `cnt`=0, and `mul_valid_o`/`r_valid_o`/`mul_result_ready_o` are deasserted. An in-flight engine result is dropped; the engine is flushed in parallel by the system.
- Reset values: state FILL, `cnt`=0, operand buffer all zeros, captured result zeros. Outputs after reset: `s_ready_o`=1, all other valids/readies 0, `busy_o`=0.
- Reset mid-operation (any state) gives the same values immediately and asynchronously.

## Timing
- Beat throughput in FILL: one per cycle, no bubbles.
- Final beat accepted at edge N → `mul_valid_o`=1 after edge N. Minimum issue latency is 1 cycle.
- `mul_ready_i` sampled at edge M → WAIT after M. A result valid at edge M+1 is captured, and `r_valid_o`=1 after M+1.
- `r_ready_i` sampled at edge R → `s_ready_o`=1 after R. Minimum loop from last beat to next fill is 4 cycles plus engine latency.
- `s_ready_o`, `mul_valid_o`, `mul_result_ready_o` and `r_valid_o` are registered state decodes. No combinational input→output paths.

## Test plan
- Basic fill/issue: 16 beats {3FF0000000000000, 4000000000000000, 401C000000000000, 4000000000000000} back-to-back → `mul_valid_o` one cycle after the 16th; every beat's lanes 0..3 appear at words 4i..4i+3.
- Engine handshake with backpressure: hold `mul_ready_i`=0 for 5 cycles → `mul_operands_o`/`mul_valid_o` stable. Responder model returns {4048000000000000, 4070000000000000} (48+256j) → `r_real_o`/`r_imag_o` match, and `r_valid_o` holds until `r_ready_i`.
- Upstream gaps: random `s_valid_i` deassertion → exactly 16 accepted beats before ISSUE, slot order preserved; `s_ready_o`=0 from ISSUE until return to FILL.
- Flush in each state (FILL at cnt=7, ISSUE, WAIT, RESULT) → next cycle FILL, cnt=0, `busy_o`=0; a late `mul_result_valid_i` is ignored.
- Async reset asserted mid-WAIT between edges → outputs at reset values immediately. After release, a full new transaction completes correctly.
- Back-to-back transactions: 3 vectors with distinct data → 3 results in order, with no stale slot data in the second or third issue.
